// File: rtl/tetris_pkg.sv
// Shared playfield types and default dimensions for the board storage and its row checkers.
package tetris_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int KIND_W = 4;

    typedef logic [3:0] kind_t;
    localparam kind_t KIND_EMPTY = 4'd0;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'd0,
        OP_CLEAR_ROW = 2'd1,
        OP_CLEAR_ALL = 2'd2
    } board_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SWEEP = 2'd2
    } board_state_e;

endpackage

// File: rtl/board_row_check.sv
// Combinational full-row detector: high when every cell of the row holds a non-empty kind.
module board_row_check #(
    parameter int COLS   = 10,
    parameter int KIND_W = 4
) (
    input  logic [COLS*KIND_W-1:0] row,
    output logic                   full
);

    logic [COLS-1:0] cell_used;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
        assign cell_used[gi] = |row[gi*KIND_W +: KIND_W];
    end

    assign full = &cell_used;

endmodule

// File: rtl/board_store.sv
// Tetris playfield storage: cell writes, row clear with gravity shift, full wipe, and a
// registered cell lookup port for the display plus registered per-row full flags.
module board_store
    import tetris_pkg::*;
#(
    parameter int COLS   = tetris_pkg::COLS,
    parameter int ROWS   = tetris_pkg::ROWS,
    parameter int KIND_W = tetris_pkg::KIND_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_x,
    input  logic [4:0]        cmd_y,
    input  logic [KIND_W-1:0] cmd_kind,
    output logic              cmd_err,
    output logic              busy,
    input  logic [4:0]        rd_x,
    input  logic [4:0]        rd_y,
    output logic [KIND_W-1:0] rd_kind,
    output logic [ROWS-1:0]   row_full
);

    localparam int ROW_W = COLS * KIND_W;

    board_state_e      state_reg;
    logic [4:0]        ptr_reg;
    logic              cmd_err_reg;
    logic [ROW_W-1:0]  row_reg [ROWS];
    logic [KIND_W-1:0] rd_kind_reg;
    logic [ROWS-1:0]   row_full_reg;
    logic [ROWS-1:0]   full_flags;

    logic cmd_x_ok;
    logic cmd_y_ok;
    logic rd_ok;

    assign cmd_x_ok = (cmd_x < 4'(COLS));
    assign cmd_y_ok = (cmd_y < 5'(ROWS));
    assign rd_ok    = (rd_x < 5'(COLS)) && (rd_y < 5'(ROWS));

    assign busy      = (state_reg != ST_IDLE);
    assign cmd_ready = ~busy;
    assign cmd_err   = cmd_err_reg;
    assign rd_kind   = rd_kind_reg;
    assign row_full  = row_full_reg;

    // Commands are only looked at in IDLE, which is exactly when cmd_ready is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            cmd_err_reg <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                row_reg[r] <= '0;
            end
        end else begin
            cmd_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                if (cmd_x_ok && cmd_y_ok) begin
                                    row_reg[cmd_y][cmd_x*KIND_W +: KIND_W] <= cmd_kind;
                                end else begin
                                    cmd_err_reg <= 1'b1;
                                end
                            end
                            OP_CLEAR_ROW: begin
                                if (cmd_y_ok) begin
                                    ptr_reg   <= cmd_y;
                                    state_reg <= ST_SHIFT;
                                end else begin
                                    cmd_err_reg <= 1'b1;
                                end
                            end
                            OP_CLEAR_ALL: begin
                                ptr_reg   <= '0;
                                state_reg <= ST_SWEEP;
                            end
                            default: cmd_err_reg <= 1'b1;
                        endcase
                    end
                end
                // Walk upward from the cleared row, pulling each row down by one.
                ST_SHIFT: begin
                    if (ptr_reg == 5'd0) begin
                        row_reg[0] <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        row_reg[ptr_reg] <= row_reg[ptr_reg - 5'd1];
                        ptr_reg          <= ptr_reg - 5'd1;
                    end
                end
                ST_SWEEP: begin
                    row_reg[ptr_reg] <= '0;
                    if (ptr_reg == 5'(ROWS - 1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        ptr_reg <= ptr_reg + 5'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_check
        board_row_check #(
            .COLS   (COLS),
            .KIND_W (KIND_W)
        ) u_row_check (
            .row  (row_reg[gi]),
            .full (full_flags[gi])
        );
    end

    // Lookup sees the array before any same-edge write, so a colliding write shows up next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_kind_reg  <= '0;
            row_full_reg <= '0;
        end else begin
            rd_kind_reg  <= rd_ok ? row_reg[rd_y][rd_x*KIND_W +: KIND_W] : KIND_EMPTY;
            row_full_reg <= full_flags;
        end
    end

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed sequences, a vector table and random commands
// compared against an array model of the playfield.
module tb_board_store;
    import tetris_pkg::*;

    localparam int C = 10;
    localparam int R = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_x = 4'd0;
    logic [4:0]  cmd_y = 5'd0;
    logic [3:0]  cmd_kind = 4'd0;
    logic        cmd_err;
    logic        busy;
    logic [4:0]  rd_x = 5'd0;
    logic [4:0]  rd_y = 5'd0;
    logic [3:0]  rd_kind;
    logic [R-1:0] row_full;

    int model [R][C];
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int op;
        int x;
        int y;
        int kind;
        int exp_err;
        int exp_busy;
    } vec_t;

    vec_t tbl [8];

    board_store dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_kind  (cmd_kind),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_kind   (rd_kind),
        .row_full  (row_full)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_clear_all();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                model[r][c] = 0;
    endfunction

    function automatic void m_apply(input int op, input int x, input int y, input int k);
        case (op)
            0: if (x < C && y < R) model[y][x] = k;
            1: if (y < R) begin
                for (int r = y; r > 0; r--)
                    for (int c = 0; c < C; c++)
                        model[r][c] = model[r-1][c];
                for (int c = 0; c < C; c++) model[0][c] = 0;
            end
            2: m_clear_all();
            default: ;
        endcase
    endfunction

    function automatic int m_err(input int op, input int x, input int y);
        if (op == 3) return 1;
        if (op == 0 && (x >= C || y >= R)) return 1;
        if (op == 1 && y >= R) return 1;
        return 0;
    endfunction

    function automatic int m_busy(input int op, input int x, input int y);
        if (m_err(op, x, y) != 0) return 0;
        if (op == 1) return y + 1;
        if (op == 2) return R;
        return 0;
    endfunction

    function automatic logic [R-1:0] m_full();
        logic [R-1:0] f;
        for (int r = 0; r < R; r++) begin
            f[r] = 1'b1;
            for (int c = 0; c < C; c++)
                if (model[r][c] == 0) f[r] = 1'b0;
        end
        return f;
    endfunction

    task automatic read_cell(input int x, input int y, output logic [3:0] k);
        rd_x = 5'(x);
        rd_y = 5'(y);
        tick();
        k = rd_kind;
    endtask

    task automatic check_board(input string tag);
        logic [3:0] k;
        for (int y = 0; y < R; y++)
            for (int x = 0; x < C; x++) begin
                read_cell(x, y, k);
                check($sformatf("%s cell(%0d,%0d)", tag, x, y), 32'(k), 32'(model[y][x]));
            end
        check($sformatf("%s row_full", tag), 32'(row_full), 32'(m_full()));
        $display("board check %s done", tag);
    endtask

    task automatic do_cmd(input int op, input int x, input int y, input int k,
                          output int busy_n, output logic err);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_x     = 4'(x);
        cmd_y     = 5'(y);
        cmd_kind  = 4'(k);
        tick();
        cmd_valid = 1'b0;
        err = cmd_err;
        busy_n = 0;
        while (busy && busy_n < 100) begin
            tick();
            busy_n++;
        end
        $display("cmd op=%0d x=%0d y=%0d kind=%0d -> err=%0b busy_cycles=%0d", op, x, y, k, err, busy_n);
    endtask

    initial begin
        int         n;
        logic       e;
        logic [3:0] k;

        // Reset state
        m_clear_all();
        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        check("reset rd_kind", 32'(rd_kind), 32'd0);
        check("reset row_full", 32'(row_full), 32'd0);
        reset_n = 1'b1;
        check_board("reset");

        // Write then read, including a read of the same cell in the write cycle
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_x = 4'd3; cmd_y = 5'd5; cmd_kind = 4'd7;
        rd_x = 5'd3; rd_y = 5'd5;
        tick();
        cmd_valid = 1'b0;
        check("same_cycle_read", 32'(rd_kind), 32'd0);
        m_apply(0, 3, 5, 7);
        tick();
        check("read_after_write", 32'(rd_kind), 32'd7);
        read_cell(4, 5, k);
        check("neighbour_read", 32'(k), 32'd0);
        read_cell(12, 5, k);
        check("oob_x_read", 32'(k), 32'd0);
        read_cell(3, 25, k);
        check("oob_y_read", 32'(k), 32'd0);

        // Fill bottom row back-to-back, then clear it
        for (int x = 0; x < C; x++) begin
            do_cmd(0, x, 19, 2, n, e);
            m_apply(0, x, 19, 2);
            check("row19_write_busy", 32'(n), 32'd0);
            check("row19_write_err", 32'(e), 32'd0);
        end
        check("row_full19_lag", 32'(row_full[19]), 32'd0);
        tick();
        check("row_full19_set", 32'(row_full[19]), 32'd1);
        do_cmd(1, 0, 19, 0, n, e);
        m_apply(1, 0, 19, 0);
        check("clear19_busy", 32'(n), 32'd20);
        check("clear19_err", 32'(e), 32'd0);
        check_board("clear19");

        // Rows 0 and 10 full, clear row 10 while a write is held during busy
        for (int x = 0; x < C; x++) begin
            do_cmd(0, x, 0, 4, n, e);
            m_apply(0, x, 0, 4);
            do_cmd(0, x, 10, 4, n, e);
            m_apply(0, x, 10, 4);
        end
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_y = 5'd10;
        tick();
        cmd_op = 2'd0; cmd_x = 4'd0; cmd_y = 5'd15; cmd_kind = 4'd9;
        n = 0;
        while (busy && n < 100) begin
            check("held_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        m_apply(1, 0, 10, 0);
        check("clear10_busy", 32'(n), 32'd11);
        check_board("clear10");

        // Vector table: rejects, edge writes, short clears
        tbl[0] = '{op: 0, x: 10, y: 0,  kind: 5,  exp_err: 1, exp_busy: 0};
        tbl[1] = '{op: 1, x: 0,  y: 20, kind: 0,  exp_err: 1, exp_busy: 0};
        tbl[2] = '{op: 3, x: 0,  y: 0,  kind: 0,  exp_err: 1, exp_busy: 0};
        tbl[3] = '{op: 0, x: 9,  y: 19, kind: 15, exp_err: 0, exp_busy: 0};
        tbl[4] = '{op: 0, x: 0,  y: 1,  kind: 0,  exp_err: 0, exp_busy: 0};
        tbl[5] = '{op: 1, x: 0,  y: 0,  kind: 0,  exp_err: 0, exp_busy: 1};
        tbl[6] = '{op: 0, x: 15, y: 31, kind: 1,  exp_err: 1, exp_busy: 0};
        tbl[7] = '{op: 2, x: 0,  y: 0,  kind: 0,  exp_err: 0, exp_busy: 20};
        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].kind, n, e);
            check($sformatf("tbl%0d err", i), 32'(e), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d busy", i), 32'(n), 32'(tbl[i].exp_busy));
            tick();
            check($sformatf("tbl%0d err_drop", i), 32'(cmd_err), 32'd0);
            if (tbl[i].exp_err == 0) m_apply(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].kind);
            check_board($sformatf("tbl%0d", i));
        end

        // Full board, CLEAR_ALL interrupted by reset at cycle 7
        for (int y = 0; y < R; y++)
            for (int x = 0; x < C; x++) begin
                int kk = $urandom_range(1, 15);
                do_cmd(0, x, y, kk, n, e);
                m_apply(0, x, y, kk);
            end
        tick();
        check("full_board_row_full", 32'(row_full), 32'(m_full()));
        cmd_valid = 1'b1; cmd_op = 2'd2;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        check("sweep_busy_before_reset", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_abort_busy", 32'(busy), 32'd0);
        check("reset_abort_ready", 32'(cmd_ready), 32'd1);
        check("reset_abort_row_full", 32'(row_full), 32'd0);
        m_clear_all();
        tick();
        reset_n = 1'b1;
        check_board("reset_abort");

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 19);
            int op;
            int x = $urandom_range(0, 10);
            int y = $urandom_range(0, 20);
            int kk = $urandom_range(0, 15);
            if (sel < 15) op = 0;
            else if (sel < 18) op = 1;
            else if (sel < 19) op = 3;
            else op = 2;
            do_cmd(op, x, y, kk, n, e);
            check($sformatf("rnd%0d err", i), 32'(e), 32'(m_err(op, x, y)));
            check($sformatf("rnd%0d busy", i), 32'(n), 32'(m_busy(op, x, y)));
            if (m_err(op, x, y) == 0) m_apply(op, x, y, kk);
            if (op == 0) begin
                read_cell(x % C, y % R, k);
                check($sformatf("rnd%0d readback", i), 32'(k), 32'(model[y % R][x % C]));
            end else begin
                check_board($sformatf("rnd%0d", i));
            end
        end
        check_board("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
